// File: rtl/xoodyak_op_sequencer.sv
// xoodyak_op_sequencer
//   Host-side command issuer for the Xoodyak core. A command taken on the
//   valid/ready command port is held on opmode/input_data for HOLD_CYCLES
//   cycles. Output-producing operations (func 4,5,6,8) then wait for the
//   core's textout_valid strobe, bounded by TIMEOUT cycles. The captured text
//   goes back on the valid/ready response port. Illegal funcs (>= 9) are
//   answered at once with an error response and never reach the core.
// Ports
//   eph1, reset                  clock (rising edge), async active-low reset
//   cmd_valid/ready/op/data      command port (op[4]=hash mode, op[3:0]=func)
//   opmode, input_data           drive to the core
//   textout, textout_valid       result from the core (1-cycle strobe)
//   rsp_valid/ready/text/op/err  response port
module xoodyak_op_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic         eph1,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [4:0]   cmd_op,
   input  logic [351:0] cmd_data,
   output logic [4:0]   opmode,
   output logic [351:0] input_data,
   input  logic [191:0] textout,
   input  logic         textout_valid,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [191:0] rsp_text,
   output logic [4:0]   rsp_op,
   output logic         rsp_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   // Funcs whose result comes back on textout.
   function automatic logic is_output_op(input logic [3:0] func);
      case (func)
         4'd4, 4'd5, 4'd6, 4'd8: is_output_op = 1'b1;
         default:                is_output_op = 1'b0;
      endcase
   endfunction

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [HW-1:0] hold_r;
   logic [TW-1:0] to_cnt_r;
   logic          pend_r;
   logic          cmd_ready_r;
   logic          rsp_valid_r;
   logic [4:0]    opmode_r;
   logic [351:0]  input_data_r;
   logic [191:0]  rsp_text_r;
   logic [4:0]    rsp_op_r;
   logic          rsp_err_r;
   logic          illegal_s;
   logic          out_op_s;
   logic          hold_done_s;
   logic          to_done_s;

   assign illegal_s   = (cmd_op[3:0] >= 4'd9);
   assign out_op_s    = is_output_op(rsp_op_r[3:0]);  // rsp_op_r holds the op in flight
   assign hold_done_s = (hold_r == {HW{1'b0}});
   assign to_done_s   = (to_cnt_r == TO_LAST);

   assign cmd_ready  = cmd_ready_r;
   assign rsp_valid  = rsp_valid_r;
   assign opmode     = opmode_r;
   assign input_data = input_data_r;
   assign rsp_text   = rsp_text_r;
   assign rsp_op     = rsp_op_r;
   assign rsp_err    = rsp_err_r;

   // Next-state decode of the command/response sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_nxt_s = illegal_s ? ST_RESP : ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!hold_done_s) begin
               state_nxt_s = ST_ISSUE;
            end else if (!out_op_s) begin
               state_nxt_s = ST_IDLE;
            end else if (pend_r || textout_valid) begin
               // Result already arrived while the operands were still held.
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (textout_valid || to_done_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, handshake flags and core/response datapath registers.
   always_ff @(posedge eph1 or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         cmd_ready_r  <= 1'b1;
         rsp_valid_r  <= 1'b0;
         hold_r       <= {HW{1'b0}};
         to_cnt_r     <= {TW{1'b0}};
         pend_r       <= 1'b0;
         opmode_r     <= 5'd0;
         input_data_r <= 352'd0;
         rsp_text_r   <= 192'd0;
         rsp_op_r     <= 5'd0;
         rsp_err_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cmd_ready_r <= (state_nxt_s == ST_IDLE);
         rsp_valid_r <= (state_nxt_s == ST_RESP);
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rsp_op_r <= cmd_op;
                  pend_r   <= 1'b0;
                  hold_r   <= HOLD_LAST;
                  if (illegal_s) begin
                     rsp_err_r  <= 1'b1;
                     rsp_text_r <= 192'd0;
                  end else begin
                     rsp_err_r    <= 1'b0;
                     opmode_r     <= cmd_op;
                     input_data_r <= cmd_data;
                  end
               end
            end
            ST_ISSUE: begin
               if (out_op_s && textout_valid) begin
                  pend_r     <= 1'b1;
                  rsp_text_r <= textout;
               end
               if (hold_done_s) begin
                  opmode_r     <= 5'd0;
                  input_data_r <= 352'd0;
                  to_cnt_r     <= {TW{1'b0}};
               end else begin
                  hold_r <= hold_r - HW'(1);
               end
            end
            ST_WAIT: begin
               // Data wins over a simultaneous timeout.
               if (textout_valid) begin
                  rsp_text_r <= textout;
                  rsp_err_r  <= 1'b0;
               end else if (to_done_s) begin
                  rsp_text_r <= 192'd0;
                  rsp_err_r  <= 1'b1;
               end else begin
                  to_cnt_r <= to_cnt_r + TW'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  pend_r <= 1'b0;
               end
            end
            default: begin
               opmode_r     <= 5'd0;
               input_data_r <= 352'd0;
            end
         endcase
      end
   end

endmodule
